register_file: RTL and testbench

- Register file that answers the control unit's register strobes: two read ports drive ALU/memory operand buses, one write port captures the shared data bus.
- 16 general registers x 16 bits; sits between the control unit, the logic unit, the comparator and the memory port.
- Read operands stay on their buses after the strobe drops. Multi-cycle sequences such as load-from-memory therefore keep a stable address without re-issuing the read.

---
 rtl/register_file.sv | 109 ++++++++++
 tb/tb_register_file.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 16x16 register file: two combinational read ports with operand hold, one write port,
// sticky uninitialised-read detection. Define REGFILE_WRITE_TRACE_EN to add write trace outputs.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reg1_read,
  input  logic                  reg2_read,
  input  logic                  reg3_write,
  input  logic [ADDR_WIDTH-1:0] reg1_addr,
  input  logic [ADDR_WIDTH-1:0] reg2_addr,
  input  logic [ADDR_WIDTH-1:0] reg3_addr,
  input  logic [DATA_WIDTH-1:0] d_bus,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic                  uninit_err,
  output logic [ADDR_WIDTH-1:0] uninit_addr
`ifdef REGFILE_WRITE_TRACE_EN
  ,
  output logic [ADDR_WIDTH-1:0] last_wr_addr,
  output logic [DATA_WIDTH-1:0] last_wr_data,
  output logic [15:0]           wr_count
`endif
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam bit ZeroEn = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_written;
  logic [DATA_WIDTH-1:0] r_holdA;
  logic [DATA_WIDTH-1:0] r_holdB;
  logic                  r_uninitErr;
  logic [ADDR_WIDTH-1:0] r_uninitAddr;

  logic                  w_zeroA;
  logic                  w_zeroB;
  logic                  w_zeroW;
  logic [DATA_WIDTH-1:0] w_rdA;
  logic [DATA_WIDTH-1:0] w_rdB;
  logic                  w_wrEn;
  logic                  w_badA;
  logic                  w_badB;

  // Reads see the pre-write contents: no write-to-read bypass.
  assign w_zeroA = ZeroEn && (reg1_addr == '0);
  assign w_zeroB = ZeroEn && (reg2_addr == '0);
  assign w_zeroW = ZeroEn && (reg3_addr == '0);
  assign w_rdA   = w_zeroA ? '0 : r_regs[reg1_addr];
  assign w_rdB   = w_zeroB ? '0 : r_regs[reg2_addr];
  assign w_wrEn  = reg3_write && !w_zeroW;
  assign w_badA  = reg1_read && !w_zeroA && !r_written[reg1_addr];
  assign w_badB  = reg2_read && !w_zeroB && !r_written[reg2_addr];

  assign op_a        = reg1_read ? w_rdA : r_holdA;
  assign op_b        = reg2_read ? w_rdB : r_holdB;
  assign uninit_err  = r_uninitErr;
  assign uninit_addr = r_uninitAddr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_written    <= '0;
      r_holdA      <= '0;
      r_holdB      <= '0;
      r_uninitErr  <= 1'b0;
      r_uninitAddr <= '0;
    end else begin
      if (w_wrEn) r_regs[reg3_addr] <= d_bus;
      if (reg3_write) r_written[reg3_addr] <= 1'b1;
      if (reg1_read) r_holdA <= w_rdA;
      if (reg2_read) r_holdB <= w_rdB;
      // Only the first offence is recorded; port A wins a same-cycle tie.
      if (!r_uninitErr && (w_badA || w_badB)) begin
        r_uninitErr  <= 1'b1;
        r_uninitAddr <= w_badA ? reg1_addr : reg2_addr;
      end
    end
  end

`ifdef REGFILE_WRITE_TRACE_EN
  logic [ADDR_WIDTH-1:0] r_lastWrAddr;
  logic [DATA_WIDTH-1:0] r_lastWrData;
  logic [15:0]           r_wrCount;

  assign last_wr_addr = r_lastWrAddr;
  assign last_wr_data = r_lastWrData;
  assign wr_count     = r_wrCount;

  // Writes dropped on the zero register are counted but leave the trace alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_lastWrAddr <= '0;
      r_lastWrData <= '0;
      r_wrCount    <= '0;
    end else begin
      if (reg3_write) r_wrCount <= r_wrCount + 16'd1;
      if (w_wrEn) begin
        r_lastWrAddr <= reg3_addr;
        r_lastWrData <= d_bus;
      end
    end
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: one instance with ZERO_REG=0 and one with ZERO_REG=1.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg1_read, reg2_read, reg3_write;
  logic [3:0]  reg1_addr, reg2_addr, reg3_addr;
  logic [15:0] d_bus;

  logic [15:0] opA, opB, opAZ, opBZ;
  logic        errN, errZ;
  logic [3:0]  addrN, addrZ;
`ifdef REGFILE_WRITE_TRACE_EN
  logic [3:0]  lwaN, lwaZ;
  logic [15:0] lwdN, lwdZ, wcN, wcZ;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .reg1_read(reg1_read), .reg2_read(reg2_read), .reg3_write(reg3_write),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg3_addr(reg3_addr),
    .d_bus(d_bus), .op_a(opA), .op_b(opB),
    .uninit_err(errN), .uninit_addr(addrN)
`ifdef REGFILE_WRITE_TRACE_EN
    , .last_wr_addr(lwaN), .last_wr_data(lwdN), .wr_count(wcN)
`endif
  );

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG(1)) dutZ (
    .clk(clk), .reset_n(reset_n),
    .reg1_read(reg1_read), .reg2_read(reg2_read), .reg3_write(reg3_write),
    .reg1_addr(reg1_addr), .reg2_addr(reg2_addr), .reg3_addr(reg3_addr),
    .d_bus(d_bus), .op_a(opAZ), .op_b(opBZ),
    .uninit_err(errZ), .uninit_addr(addrZ)
`ifdef REGFILE_WRITE_TRACE_EN
    , .last_wr_addr(lwaZ), .last_wr_data(lwdZ), .wr_count(wcZ)
`endif
  );

  // Drives one cycle's worth of inputs and lets combinational outputs settle.
  task automatic applyStimulus(input logic rst_n, input logic r1, input logic [3:0] a1,
                               input logic r2, input logic [3:0] a2,
                               input logic w, input logic [3:0] a3, input logic [15:0] d);
    reset_n    = rst_n;
    reg1_read  = r1;  reg1_addr = a1;
    reg2_read  = r2;  reg2_addr = a2;
    reg3_write = w;   reg3_addr = a3;
    d_bus      = d;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);
  endtask

  // Advance past the next rising edge, sampling well after it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    @(negedge clk);
    // Reset
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);
    step(); step();
    idle();
    checkOutput("rst_op_a", opA, 16'h0000);
    checkOutput("rst_op_b", opB, 16'h0000);
    checkOutput("rst_err", {15'd0, errN}, 16'h0000);
    checkOutput("rst_addr", {12'd0, addrN}, 16'h0000);

    // Write r5, read it, hold it over idle cycles
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 16'h1234); step();
    applyStimulus(1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);
    checkOutput("rd_r5_strobe", opA, 16'h1234);
    step(); idle(); step(); step();
    checkOutput("rd_r5_hold", opA, 16'h1234);
    checkOutput("no_err_after_valid_reads", {15'd0, errN}, 16'h0000);

    // Same-cycle read/write of r3 returns the old value
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd3, 16'h00FF); step();
    applyStimulus(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 4'd3, 16'h0100);
    checkOutput("rw_same_old", opA, 16'h00FF);
    step(); idle();
    checkOutput("rw_hold_old", opA, 16'h00FF);
    applyStimulus(1'b1, 1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000);
    checkOutput("rw_next_new", opA, 16'h0100);
    step();

    // Port B holds across an unrelated write
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd7, 16'h8000); step();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 4'd7, 1'b0, 4'd0, 16'h0000);
    checkOutput("rd_b_r7", opB, 16'h8000);
    step();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd2, 16'hBEEF);
    checkOutput("hold_b_during_wr", opB, 16'h8000);
    step(); idle();
    checkOutput("hold_b_after_wr", opB, 16'h8000);
    applyStimulus(1'b1, 1'b1, 4'd2, 1'b1, 4'd2, 1'b0, 4'd0, 16'h0000);
    checkOutput("rd_a_r2", opA, 16'hBEEF);
    checkOutput("rd_b_r2", opB, 16'hBEEF);
    step();

    // Uninitialised reads on both ports: port A index recorded
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); step();
    applyStimulus(1'b1, 1'b1, 4'd9, 1'b1, 4'd4, 1'b0, 4'd0, 16'h0000);
    checkOutput("uninit_pre_err", {15'd0, errN}, 16'h0000);
    checkOutput("uninit_op_b", opB, 16'h0000);
    step(); idle();
    checkOutput("uninit_err", {15'd0, errN}, 16'h0001);
    checkOutput("uninit_addr", {12'd0, addrN}, 16'h0009);
    applyStimulus(1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); step(); idle();
    checkOutput("uninit_sticky_err", {15'd0, errN}, 16'h0001);
    checkOutput("uninit_addr_kept", {12'd0, addrN}, 16'h0009);

    // Zero register behaviour on both instances
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 16'h0000); step();
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 16'hFFFF); step();
    applyStimulus(1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 16'h0000);
    checkOutput("z_op_a", opAZ, 16'h0000);
    checkOutput("z_op_b", opBZ, 16'h0000);
    checkOutput("nz_op_a_r0", opA, 16'hFFFF);
    step(); idle();
    checkOutput("z_hold_a", opAZ, 16'h0000);
    checkOutput("z_no_err", {15'd0, errZ}, 16'h0000);
`ifdef REGFILE_WRITE_TRACE_EN
    checkOutput("z_wr_count", wcZ, 16'h0001);
    checkOutput("z_last_data", lwdZ, 16'h0000);
    checkOutput("nz_last_data", lwdN, 16'hFFFF);
`endif
    // Reading r0 after the dropped write on the ZERO_REG=1 instance: an uninit read of r1 flags it
    applyStimulus(1'b1, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd0, 16'h0000); step(); idle();
    checkOutput("z_uninit_addr", {12'd0, addrZ}, 16'h0001);

    // Reset discards contents and a write presented during reset
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd1, 16'hAAAA); step();
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd6, 16'h1111); step();
    applyStimulus(1'b1, 1'b1, 4'd1, 1'b1, 4'd6, 1'b0, 4'd0, 16'h0000);
    checkOutput("post_rst_r1", opA, 16'h0000);
    checkOutput("post_rst_r6", opB, 16'h0000);
    checkOutput("post_rst_err_clear", {15'd0, errN}, 16'h0000);
`ifdef REGFILE_WRITE_TRACE_EN
    checkOutput("post_rst_wr_count", wcN, 16'h0000);
`endif
    step(); idle();
    checkOutput("post_rst_err", {15'd0, errN}, 16'h0001);
    checkOutput("post_rst_addr", {12'd0, addrN}, 16'h0001);
`ifdef REGFILE_WRITE_TRACE_EN
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd12, 16'h5A5A); step(); idle();
    checkOutput("trace_wr_count", wcN, 16'h0001);
    checkOutput("trace_addr", {12'd0, lwaN}, 16'h000C);
    checkOutput("trace_data", lwdN, 16'h5A5A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
